// File: rtl/mux_n_pipe.sv
// mux_n_pipe: NUM_IN:1 selector of WIDTH-bit lines with a registered output
// stage, valid/ready handshake, flush, and sticky out-of-range select flag.
//
// Optional build macro: MUX_N_PIPE_SKID_EN
//   defined   -> in_ready is registered and a one-entry skid buffer holds
//                one extra transfer while the output is stalled (2 entries).
//   undefined -> in_ready = !out_valid || out_ready, single output register.
//
// Handshake: a transfer on either side happens on a rising edge where the
// producer's valid and the consumer's ready are both 1. valid must not
// depend on ready. While out_valid && !out_ready, out_data and out_valid
// are held unchanged. flush drops everything held and any same-cycle input.
module mux_n_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_lines,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  logic [WIDTH-1:0] sel_val;
  logic             sel_bad;
  logic             accept;

  // Select the addressed line; an unmatched select yields zero and flags it.
  always_comb begin
    sel_val = '0;
    sel_bad = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_val = in_lines[k*WIDTH +: WIDTH];
        sel_bad = 1'b0;
      end
    end
  end

  // A transfer in the flush cycle is discarded, so it never counts as accepted.
  assign accept = in_valid && in_ready && !flush;

  // Sticky error: set by any accepted out-of-range select, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (accept && sel_bad) begin
      sel_err <= 1'b1;
    end
  end

`ifdef MUX_N_PIPE_SKID_EN

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             in_ready_r;

  // in_ready_r always equals !skid_valid; being a flop it breaks the
  // out_ready -> in_ready path.
  assign in_ready = in_ready_r;

  // Output register plus skid entry: the skid only fills while the output
  // is stalled, and is always drained into the output first so order holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      in_ready_r <= 1'b1;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_r <= 1'b1;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        // in_ready is low while the skid is full, so no accept can coincide.
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
        in_ready_r <= 1'b1;
      end else if (accept) begin
        out_data  <= sel_val;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data  <= sel_val;
      skid_valid <= 1'b1;
      in_ready_r <= 1'b0;
    end
  end

`else

  // Ready whenever the output register is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;

  // Single output register: load on accept, clear valid on drain, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_data  <= sel_val;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: randomized and directed stimulus for mux_n_pipe with a
// queue-based reference model of the held entries and a negedge monitor.
module tb_mux_n_pipe;
  localparam int WIDTH  = 32;
  localparam int NUM_IN = 5;
  localparam int SEL_W  = $clog2(NUM_IN);
`ifdef MUX_N_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_IN*WIDTH-1:0] in_lines;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;

  logic [WIDTH-1:0] lines [NUM_IN];
  logic [WIDTH-1:0] exp_q [$];
  bit               err_m;
  bit               mon_en;
  int               checks;
  int               failures;
  int               beats;

  mux_n_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk(clk), .rst(rst), .in_lines(in_lines), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err)
  );

  // clock
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NUM_IN; k++) in_lines[k*WIDTH +: WIDTH] = lines[k];
  end

  function automatic bit exp_ready(input int sz, input logic ordy);
    if (SKID) return sz < 2;
    return (sz == 0) || ordy;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the queue holds entries in the block, head = output.
  always @(posedge clk) begin
    if (mon_en) begin
      int  sz;
      bit  rdy;
      sz  = exp_q.size();
      rdy = exp_ready(sz, out_ready);
      if (rst) begin
        exp_q.delete();
        err_m = 1'b0;
      end else if (flush) begin
        exp_q.delete();
      end else begin
        if (sz > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && rdy) begin
          if (int'(in_sel) < NUM_IN) exp_q.push_back(lines[in_sel]);
          else begin
            exp_q.push_back('0);
            err_m = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: compare DUT outputs against the model away from the clock edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", WIDTH'(out_valid), WIDTH'(exp_q.size() > 0));
      if (out_valid && exp_q.size() > 0) begin
        check("out_data", out_data, exp_q[0]);
        if (out_ready) beats++;
      end
      check("in_ready", WIDTH'(in_ready), WIDTH'(exp_ready(exp_q.size(), out_ready)));
      check("sel_err", WIDTH'(sel_err), WIDTH'(err_m));
    end
  end

  // Driver: apply one cycle of inputs, then move just past the rising edge.
  task automatic step(input logic v, input int s, input logic ordy,
                      input logic fl, input logic r);
    in_valid  = v;
    in_sel    = SEL_W'(s);
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fixed_lines();
    for (int k = 0; k < NUM_IN; k++) lines[k] = WIDTH'((k + 1) * 'h11);
  endtask

  initial begin
    checks = 0; failures = 0; beats = 0; mon_en = 1'b0; err_m = 1'b0;
    for (int k = 0; k < NUM_IN; k++) lines[k] = $urandom;
    // reset with random inputs
    step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), 1'b0, 1'b1);
    mon_en = 1'b1;
    step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), 1'b0, 1'b1);
    check("reset out_data", out_data, '0);
    set_fixed_lines();
    // single select, then stream 0..3
    step(1'b1, 2, 1'b1, 1'b0, 1'b0);
    check("sel2 out_data", out_data, 32'h33);
    for (int i = 0; i < 4; i++) step(1'b1, i, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    // stall for 5 cycles with input pressure, then drain
    step(1'b1, 4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, i % 4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    // out-of-range select, then good transfers: error stays set
    step(1'b1, 7, 1'b1, 1'b0, 1'b0);
    check("bad sel data", out_data, '0);
    for (int i = 0; i < 4; i++) step(1'b1, i, 1'b1, 1'b0, 1'b0);
    // stalled output, flush with in_valid
    step(1'b1, 1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b1);
    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NUM_IN; k++) lines[k] = $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 300) == 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    checks++;
    if (beats < 100) begin
      failures++;
      $display("FAIL traffic: %0d output beats, expected at least 100", beats);
    end
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
